// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
// State encoding used by the control FSM.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_fa_cell.sv
// One-bit full adder.
// This is the single arithmetic slice of the serial datapath.
module fa_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_cout
);

  assign o_s    = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial ripple-borrow subtractor: d = a - b - bin.
// Processes one bit per clock through one full-adder cell.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-2:0] r_res;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_amsb;
  logic             r_bmsb;
  logic [WIDTH-1:0] r_d;
  logic             r_bout;
  logic             r_zero;
  logic             r_ovf;

  logic             w_sum;
  logic             w_cout;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_res_nx;

  fa_cell u_fa (
    .i_a    (r_sa[0]),
    .i_b    (r_sb[0]),
    .i_cin  (r_carry),
    .o_s    (w_sum),
    .o_cout (w_cout)
  );

  assign w_accept = start &&
    ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last = (r_state == S_SHIFT) &&
    (r_cnt == LAST);
  assign w_res_nx = {w_sum, r_res};

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_SHIFT;
      S_SHIFT: if (r_cnt == LAST) w_next = S_DONE;
      S_DONE:  w_next = start ? S_SHIFT : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (r_state)
      S_SHIFT: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Subtraction as a + ~b + ~bin; borrow is the inverted carry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sa    <= '0;
      r_sb    <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_amsb  <= 1'b0;
      r_bmsb  <= 1'b0;
      r_d     <= '0;
      r_bout  <= 1'b0;
      r_zero  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_sa    <= a;
      r_sb    <= ~b;
      r_carry <= ~bin;
      r_cnt   <= '0;
      r_amsb  <= a[WIDTH-1];
      r_bmsb  <= b[WIDTH-1];
    end else if (r_state == S_SHIFT) begin
      r_sa    <= r_sa >> 1;
      r_sb    <= r_sb >> 1;
      r_carry <= w_cout;
      r_res   <= w_res_nx[WIDTH-1:1];
      if (!w_last) r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_d    <= w_res_nx;
        r_bout <= ~w_cout;
        r_zero <= (w_res_nx == '0);
        r_ovf  <= (r_amsb != r_bmsb) &&
                  (w_sum != r_amsb);
      end
    end
  end

  assign d    = r_d;
  assign bout = r_bout;
  assign zero = r_zero;
  assign ovf  = r_ovf;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial ripple-borrow subtractor, the subtract-side companion to the team's parallel ripple-carry adder.
- Computes D = A - B - bin on WIDTH-bit operands, one bit per clock, through a single full-adder cell.
- Control is a start/busy/done handshake.
- Used where area matters more than latency, e.g. lab datapaths sharing one adder cell.

Parameters:
WIDTH, 4, operand/result width in bits (>=2).

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only when state is IDLE or DONE
a  input  WIDTH  minuend; captured on accepted start
b  input  WIDTH  subtrahend; captured on accepted start
bin  input  1  borrow-in; captured on accepted start
busy  output  1  high while state is SHIFT
done  output  1  one-cycle pulse, high while state is DONE
d  output  WIDTH  difference; registered, held until next completion
bout  output  1  borrow-out (1 = unsigned a < b+bin)
zero  output  1  d == 0, registered with d
ovf  output  1  signed overflow of a - b - bin, registered with d

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset: state=IDLE; busy, done, d, bout, zero, ovf all 0; internal shift registers, counter and carry cleared.
- rst has priority over every other input, including start on the same edge.
- States: IDLE, SHIFT, DONE.
- IDLE: start=1 at edge E0 captures a, b and bin into shift registers as follows:
  - sa = a, sb = ~b, carry = ~bin, cnt = 0.
  - Next state SHIFT. start=0 stays in IDLE.
- SHIFT, each edge:
  - sum = sa[0]^sb[0]^carry, with carry-out from the full-adder cell.
  - sum shifts into the result register from the MSB side (right shift), so bit 0 lands at position 0 after WIDTH shifts.
  - sa and sb shift right; cnt increments.
- At the edge where cnt == WIDTH-1, i.e. edge E0+WIDTH, the final bit is processed and these update on that same edge:
  - d = full result.
  - bout = ~final carry.
  - zero = (result == 0).
  - ovf = (a[MSB] != b[MSB]) && (d[MSB] != a[MSB]), using the captured operand MSBs.
  - State moves to DONE.
- DONE: done=1 for exactly one cycle.
  - Next edge: start=1 is accepted exactly as in IDLE (back-to-back, no idle gap); otherwise go to IDLE.
- Latency: done is high in the cycle following edge E0+WIDTH. Throughput is one operation per WIDTH+1 cycles.
- start while busy: ignored. Captured operands are unaffected, and a, b, bin may change freely during SHIFT.
- Outputs d/bout/zero/ovf hold their last values through IDLE and SHIFT. They change only at completion or reset.
- rst mid-SHIFT: operation is aborted, no done pulse, all outputs cleared. The next start behaves as after power-up reset.
- Arithmetic is modulo 2^WIDTH. bin=1 with a==b gives d = all ones, bout=1.
- cnt is $clog2(WIDTH) bits wide and never wraps past WIDTH-1.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2).
- Sub-module: fa_cell, a one-bit full adder (a, b, cin -> s, cout), instantiated once for the serial bit slice.
- Control FSM, counter and shift registers stay in serial_subtractor.

Test Plan:
1. a=9, b=3, bin=0, start pulse -> done 4 cycles after start edge; d=4'h6, bout=0, zero=0, ovf=0.
2. a=3, b=5, bin=0 -> d=4'hE, bout=1, zero=0, ovf=0.
3. a=4'h7, b=4'h8, bin=0 -> d=4'hF, bout=1, ovf=1. Then a=4'h8, b=4'h1 -> d=4'h7, bout=0, ovf=1.
4. a=5, b=4, bin=1 -> d=0, zero=1, bout=0. Then a=5, b=5, bin=1 -> d=4'hF, bout=1, zero=0.
5. start held high continuously with changing a/b -> busy-cycle starts ignored, results match operands captured at each IDLE/DONE acceptance, back-to-back done pulses every 5 cycles.
6. rst asserted 2 cycles into SHIFT -> next cycle all outputs 0, state IDLE, no done. A following a=12, b=7 operation gives d=4'h5, bout=0.
